alu_issue_stage: RTL and testbench

//  Producer side of the ALU interface: decodes RISC-V opcode/funct3/funct7 into the 4-bit ALU Operation code.

---
 rtl/alu_ops_pkg.sv | 41 ++++
 rtl/alu_op_decode.sv | 86 ++++++++
 rtl/alu_issue_stage.sv | 136 +++++++++++++
 tb/tb_alu_issue_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ops_pkg.sv
// Shared ALU op codes, RISC-V major opcodes and skid-buffer state encoding
// for the ID->EX issue stage.
package alu_ops_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_LUI = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_BLT = 4'b0110,
        ALU_BGE = 4'b0111,
        ALU_BEQ = 4'b1000,
        ALU_BNE = 4'b1001,
        ALU_SUB = 4'b1010,
        ALU_ADD = 4'b1011,
        ALU_SLT = 4'b1100,
        ALU_SRA = 4'b1101,
        ALU_JAL = 4'b1110
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // EMPTY: no entry; ONE: MAIN holds an entry; FULL: MAIN and SKID both held.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7 into the ALU op code plus
// operand selection. Unsupported encodings zero everything and flag illegal.
module alu_op_decode
    import alu_ops_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [6:0]            opcode_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output alu_op_e               op_o,
    output logic [DATA_WIDTH-1:0] src_a_o,
    output logic [DATA_WIDTH-1:0] src_b_o,
    output logic                  illegal_o
);

    // Immediate shifts only use the low five immediate bits as the shift amount.
    logic [DATA_WIDTH-1:0] shamt;
    assign shamt = {{(DATA_WIDTH-5){1'b0}}, imm_i[4:0]};

    // Decode op and operands; illegal encodings are scrubbed at the end.
    always_comb begin
        op_o      = ALU_AND;
        src_a_o   = '0;
        src_b_o   = '0;
        illegal_o = 1'b0;
        case (opcode_i)
            OPC_OP, OPC_OP_IMM: begin
                src_a_o = rs1_i;
                src_b_o = (opcode_i == OPC_OP) ? rs2_i : imm_i;
                case (funct3_i)
                    3'b000: op_o = (opcode_i == OPC_OP && funct7_i == F7_ALT) ? ALU_SUB : ALU_ADD;
                    3'b111: op_o = ALU_AND;
                    3'b110: op_o = ALU_OR;
                    3'b100: op_o = ALU_XOR;
                    3'b010: op_o = ALU_SLT;
                    3'b001: begin
                        op_o = ALU_SLL;
                        if (opcode_i == OPC_OP_IMM) src_b_o = shamt;
                    end
                    3'b101: begin
                        op_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
                        if (opcode_i == OPC_OP_IMM) src_b_o = shamt;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: begin
                op_o    = ALU_ADD;
                src_a_o = rs1_i;
                src_b_o = imm_i;
            end
            OPC_BRANCH: begin
                src_a_o = rs1_i;
                src_b_o = rs2_i;
                case (funct3_i)
                    3'b000:  op_o = ALU_BEQ;
                    3'b001:  op_o = ALU_BNE;
                    3'b100:  op_o = ALU_BLT;
                    3'b101:  op_o = ALU_BGE;
                    default: illegal_o = 1'b1;
                endcase
            end
            OPC_LUI: begin
                op_o    = ALU_LUI;
                src_b_o = imm_i;
            end
            OPC_JAL: begin
                op_o    = ALU_JAL;
                src_a_o = pc_i;
                src_b_o = imm_i;
            end
            default: illegal_o = 1'b1;
        endcase
        if (illegal_o) begin
            op_o    = ALU_AND;
            src_a_o = '0;
            src_b_o = '0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes into ALU operands and holds them in a
// MAIN/SKID pair so the registered in_ready still allows full throughput.
module alu_issue_stage
    import alu_ops_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [DATA_WIDTH-1:0]    imm,
    input  logic [DATA_WIDTH-1:0]    pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal
);

    alu_op_e               dec_op;
    logic [DATA_WIDTH-1:0] dec_a, dec_b;
    logic                  dec_ill;

    alu_op_decode #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
        .opcode_i  (opcode),
        .funct3_i  (funct3),
        .funct7_i  (funct7),
        .rs1_i     (rs1_data),
        .rs2_i     (rs2_data),
        .imm_i     (imm),
        .pc_i      (pc),
        .op_o      (dec_op),
        .src_a_o   (dec_a),
        .src_b_o   (dec_b),
        .illegal_o (dec_ill)
    );

    state_e                state_q, state_d;
    logic                  in_ready_q;
    alu_op_e               main_op_q, skid_op_q;
    logic [DATA_WIDTH-1:0] main_a_q, main_b_q, skid_a_q, skid_b_q;
    logic                  main_ill_q, skid_ill_q;

    logic accept, drain;
    logic load_main, main_from_skid, load_skid;

    // An offer made in a flush cycle is discarded, so flush gates accept.
    assign accept = in_valid && in_ready_q && !flush;
    assign drain  = out_valid && out_ready;

    // Next state and entry-register load selects.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_ONE;
                        load_main = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_d        = ST_ONE;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State, registered ready, and the MAIN/SKID entry registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_op_q  <= ALU_AND;
            main_a_q   <= '0;
            main_b_q   <= '0;
            main_ill_q <= 1'b0;
            skid_op_q  <= ALU_AND;
            skid_a_q   <= '0;
            skid_b_q   <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
            if (load_main) begin
                main_op_q  <= main_from_skid ? skid_op_q  : dec_op;
                main_a_q   <= main_from_skid ? skid_a_q   : dec_a;
                main_b_q   <= main_from_skid ? skid_b_q   : dec_b;
                main_ill_q <= main_from_skid ? skid_ill_q : dec_ill;
            end
            if (load_skid) begin
                skid_op_q  <= dec_op;
                skid_a_q   <= dec_a;
                skid_b_q   <= dec_b;
                skid_ill_q <= dec_ill;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign SrcA      = main_a_q;
    assign SrcB      = main_b_q;
    assign Operation = OPCODE_LENGTH'(main_op_q);
    assign illegal   = main_ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] rs1_data = '0, rs2_data = '0, imm = '0, pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  Operation;
    logic        illegal;

    alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ill;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    ent_t       mq[$];
    bit         m_rdy = 1'b1;
    bit         m_live = 1'b0;
    logic [3:0] log_q[$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the op-code table.
    function automatic ent_t ref_dec(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] r1, input logic [31:0] r2,
                                     input logic [31:0] im, input logic [31:0] p);
        ent_t e;
        bit   is_r, is_i;
        e.ill = 0; e.op = 4'h0; e.a = 0; e.b = 0;
        is_r = (opc == 7'h33);
        is_i = (opc == 7'h13);
        if (is_r || is_i) begin
            e.a = r1;
            e.b = is_r ? r2 : ((f3 == 3'd1 || f3 == 3'd5) ? (im & 32'h1f) : im);
            if (f3 == 3'd0)      e.op = (is_r && f7 == 7'h20) ? 4'd10 : 4'd11;
            else if (f3 == 3'd7) e.op = 4'd0;
            else if (f3 == 3'd6) e.op = 4'd1;
            else if (f3 == 3'd4) e.op = 4'd3;
            else if (f3 == 3'd1) e.op = 4'd4;
            else if (f3 == 3'd5) e.op = f7[5] ? 4'd13 : 4'd5;
            else if (f3 == 3'd2) e.op = 4'd12;
            else                 e.ill = 1;
        end else if (opc == 7'h03 || opc == 7'h23 || opc == 7'h67) begin
            e.op = 4'd11; e.a = r1; e.b = im;
        end else if (opc == 7'h63) begin
            e.a = r1; e.b = r2;
            if (f3 == 3'd0)      e.op = 4'd8;
            else if (f3 == 3'd1) e.op = 4'd9;
            else if (f3 == 3'd4) e.op = 4'd6;
            else if (f3 == 3'd5) e.op = 4'd7;
            else                 e.ill = 1;
        end else if (opc == 7'h37) begin
            e.op = 4'd2; e.b = im;
        end else if (opc == 7'h6f) begin
            e.op = 4'd14; e.a = p; e.b = im;
        end else begin
            e.ill = 1;
        end
        if (e.ill) begin e.op = 0; e.a = 0; e.b = 0; end
        return e;
    endfunction

    // Small ALU used to show the issued operands compute the right result.
    function automatic logic [31:0] alu_eval(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd10:   return a - b;
            4'd11:   return a + b;
            4'd0:    return a & b;
            4'd1:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Reference model: a FIFO of at most two decoded entries.
    always @(posedge clk) begin
        bit acc;
        if (reset) begin
            mq.delete();
            m_rdy  = 1'b1;
            m_live = 1'b1;
        end else if (m_live) begin
            if (flush) begin
                mq.delete();
                m_rdy = 1'b1;
            end else begin
                acc = in_valid && m_rdy;
                if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                if (acc) mq.push_back(ref_dec(opcode, funct3, funct7, rs1_data, rs2_data, imm, pc));
                m_rdy = (mq.size() < 2);
            end
        end
    end

    // Log of ops actually handed to EX, in order.
    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) log_q.push_back(Operation);
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (m_live && !reset) begin
            chk("out_valid", out_valid, mq.size() > 0);
            chk("in_ready", in_ready, m_rdy);
            if (mq.size() > 0) begin
                chk("Operation", Operation, mq[0].op);
                chk("SrcA", SrcA, mq[0].a);
                chk("SrcB", SrcB, mq[0].b);
                chk("illegal", illegal, mq[0].ill);
            end
        end
    end

    task automatic set_in(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
        opcode = opc; funct3 = f3; funct7 = f7;
        rs1_data = r1; rs2_data = r2; imm = im; pc = 32'h1000;
        in_valid = 1'b1;
    endtask

    // Offer one instruction and hold it until accepted (bounded).
    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
        int n;
        bit acc;
        n = 0;
        set_in(opc, f3, f7, r1, r2, im);
        do begin
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] opcs [10];
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h63, 7'h37, 7'h6f, 7'h73, 7'h00};

        // Reset
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_Operation", Operation, 0);
        chk("rst_SrcA", SrcA, 0);
        chk("rst_SrcB", SrcB, 0);
        chk("rst_in_ready", in_ready, 1);

        // SUB 10 - 3
        out_ready = 1'b1;
        send(7'h33, 3'd0, 7'h20, 32'd10, 32'd3, 32'd0);
        @(negedge clk);
        chk("sub_op", Operation, 4'b1010);
        chk("sub_a", SrcA, 32'd10);
        chk("sub_b", SrcB, 32'd3);
        chk("sub_alu", alu_eval(Operation, SrcA, SrcB), 32'd7);

        // SRAI / SRLI shift amount
        send(7'h13, 3'd5, 7'h20, 32'h8000_0000, 32'd0, 32'h404);
        @(negedge clk);
        chk("srai_op", Operation, 4'b1101);
        chk("srai_b", SrcB, 32'd4);
        send(7'h13, 3'd5, 7'h00, 32'h8000_0000, 32'd0, 32'h404);
        @(negedge clk);
        chk("srli_op", Operation, 4'b0101);
        chk("srli_b", SrcB, 32'd4);
        idle(2);

        // Back-pressure: ADDI, XORI, BEQ
        log_q.delete();
        out_ready = 1'b0;
        send(7'h13, 3'd0, 7'h00, 32'd1, 32'd0, 32'd5);
        send(7'h13, 3'd4, 7'h00, 32'd2, 32'd0, 32'd6);
        set_in(7'h63, 3'd0, 7'h00, 32'd3, 32'd3, 32'd0);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_head_op", Operation, 4'b1011);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(7'h63, 3'd0, 7'h00, 32'd3, 32'd3, 32'd0);
        idle(4);
        chk("bp_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("bp_order0", log_q[0], 4'b1011);
            chk("bp_order1", log_q[1], 4'b0011);
            chk("bp_order2", log_q[2], 4'b1000);
        end

        // Flush in FULL with an offer pending
        out_ready = 1'b0;
        send(7'h33, 3'd0, 7'h00, 32'd4, 32'd4, 32'd0);
        send(7'h33, 3'd6, 7'h00, 32'd5, 32'd5, 32'd0);
        log_q.delete();
        set_in(7'h33, 3'd7, 7'h00, 32'd6, 32'd6, 32'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        // Flush in ONE with an acceptable offer: offer is dropped
        send(7'h13, 3'd7, 7'h00, 32'd7, 32'd0, 32'd7);
        set_in(7'h13, 3'd6, 7'h00, 32'd8, 32'd0, 32'd8);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1;
        idle(4);
        chk("fl_nothing_out", log_q.size(), 0);

        // Illegal encodings
        send(7'h13, 3'd3, 7'h00, 32'd9, 32'd9, 32'd9);
        @(negedge clk);
        chk("sltiu_ill", illegal, 1);
        chk("sltiu_op", Operation, 0);
        chk("sltiu_a", SrcA, 0);
        chk("sltiu_b", SrcB, 0);
        send(7'h73, 3'd0, 7'h00, 32'd9, 32'd9, 32'd9);
        @(negedge clk);
        chk("system_ill", illegal, 1);
        chk("system_op", Operation, 0);

        // Random traffic, flushes and occasional reset
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset     = ($urandom_range(0, 599) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            opcode    = opcs[$urandom_range(0, 9)];
            funct3    = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       funct7 = 7'h00;
                1:       funct7 = 7'h20;
                default: funct7 = 7'($urandom);
            endcase
            rs1_data = $urandom; rs2_data = $urandom;
            imm = $urandom; pc = $urandom;
        end
        @(posedge clk); #1;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
